// File: rtl/axi_sram_slave.sv
// AXI3-style slave bridging single-outstanding bursts onto a synchronous word-wide SRAM.
// One transaction is in flight at a time; reads take priority over writes in idle.
module axi_sram_slave #(
  parameter int unsigned RAM_AW = 16
) (
  input  logic              aclk,
  input  logic              aresetn,
  // AR channel
  input  logic [3:0]        arid,
  input  logic [31:0]       araddr,
  input  logic [3:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic              arvalid,
  output logic              arready,
  // R channel
  output logic [3:0]        rid,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  // AW channel
  input  logic [3:0]        awid,
  input  logic [31:0]       awaddr,
  input  logic [3:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic              awvalid,
  output logic              awready,
  // W channel
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  // B channel
  output logic [3:0]        bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  // SRAM port
  output logic              ram_en,
  output logic [3:0]        ram_wen,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StWresp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  id_q, id_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  len_q, len_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  burst_q, burst_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [31:0] addr_nxt;

  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [3:0] len,
                                            input logic [2:0] size, input logic [1:0] burst);
    logic [1:0]  sz;
    logic [31:0] incr;
    logic [31:0] mask;
    logic [31:0] res;
    sz   = (size > 3'd2) ? 2'd2 : size[1:0];
    incr = 32'd1 << sz;
    // Wrap window is (len+1) beats of the transfer size, aligned to its own length.
    mask = (({28'd0, len} + 32'd1) << sz) - 32'd1;
    case (burst)
      2'b00:   res = a;
      2'b10:   res = (a & ~mask) | ((a + incr) & mask);
      default: res = a + incr;
    endcase
    return res;
  endfunction

  assign addr_nxt = next_addr(addr_q, len_q, size_q, burst_q);

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    arready   = 1'b0;
    awready   = 1'b0;
    wready    = 1'b0;
    rvalid    = 1'b0;
    rlast     = 1'b0;
    bvalid    = 1'b0;
    bresp     = 2'b00;
    rresp     = 2'b00;
    rid       = id_q;
    bid       = id_q;
    rdata     = ram_rdata;
    ram_en    = 1'b0;
    ram_wen   = 4'b0000;
    ram_addr  = addr_q[RAM_AW+1:2];
    ram_wdata = wdata;

    unique case (state_q)
      StIdle: begin
        arready = 1'b1;
        awready = ~arvalid;
        if (arvalid) begin
          id_d     = arid;
          addr_d   = araddr;
          len_d    = arlen;
          size_d   = arsize;
          burst_d  = arburst;
          cnt_d    = 4'd0;
          err_d    = 1'b0;
          ram_en   = 1'b1;
          ram_addr = araddr[RAM_AW+1:2];
          state_d  = StRd;
        end else if (awvalid) begin
          id_d    = awid;
          addr_d  = awaddr;
          len_d   = awlen;
          size_d  = awsize;
          burst_d = awburst;
          cnt_d   = 4'd0;
          err_d   = 1'b0;
          state_d = StWr;
        end
      end
      StRd: begin
        rvalid = 1'b1;
        rlast  = (cnt_q == len_q);
        if (rready) begin
          if (cnt_q == len_q) begin
            state_d = StIdle;
          end else begin
            cnt_d    = cnt_q + 4'd1;
            addr_d   = addr_nxt;
            ram_en   = 1'b1;
            ram_addr = addr_nxt[RAM_AW+1:2];
          end
        end
      end
      StWr: begin
        wready = 1'b1;
        if (wvalid) begin
          // Inside WR the error flag can only have come from an overrun beat.
          if (cnt_q <= len_q && !err_q) begin
            ram_en  = 1'b1;
            ram_wen = wstrb;
          end else begin
            err_d = 1'b1;
          end
          cnt_d  = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
          addr_d = addr_nxt;
          if (wlast) begin
            if (cnt_q != len_q) err_d = 1'b1;
            state_d = StWresp;
          end
        end
      end
      StWresp: begin
        bvalid = 1'b1;
        bresp  = err_q ? 2'b10 : 2'b00;
        if (bready) begin
          err_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= StIdle;
      id_q    <= 4'd0;
      addr_q  <= 32'd0;
      len_q   <= 4'd0;
      size_q  <= 3'd0;
      burst_q <= 2'd0;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule
